// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FIFO_DEPTH-entry first-word-fall-through buffer.
// Byte visible 9.5 bit times + 3 cycles after the start edge; a full FIFO drops new bytes and flags OVERRUN.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       OVERRUN,
    output logic       FRAME_ERR,
    input  logic       ERR_CLR,
    output logic       BUSY
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic             sync1_q, sync2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shreg_q;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic rxs;
    logic stop_tick, push, pop, full, push_ok, push_drop, frame_bad;

    assign rxs       = sync2_q;
    assign stop_tick = (state_q == ST_STOP) && (cnt_q == BIT_END);
    assign push      = stop_tick && rxs;
    assign frame_bad = stop_tick && !rxs;
    assign pop       = (count_q != '0) && RX_READY;
    assign full      = (count_q == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok   = push && (!full || pop);
    assign push_drop = push && full && !pop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            sync1_q <= RXD;
            sync2_q <= sync1_q;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rxs) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q   <= '0;
                        shreg_q <= {rxs, shreg_q[7:1]};
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q   <= '0;
                        state_q <= rxs ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error wins over a coincident clear.
        overrun_d   = (overrun_q && !ERR_CLR) || push_drop;
        frame_err_d = (frame_err_q && !ERR_CLR) || frame_bad;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shreg_q;
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign RX_DATA   = mem_q[rd_ptr_q];
    assign RX_VALID  = (count_q != '0);
    assign OVERRUN   = overrun_q;
    assign FRAME_ERR = frame_err_q;
    assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (434 clocks per bit).
module tb_uart_rx_fifo;

    localparam int CPB = 434;
    localparam int LAT = 9 * CPB + CPB / 2 + 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RXD = 1'b1;
    logic       RX_READY = 1'b0;
    logic       ERR_CLR = 1'b0;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       OVERRUN;
    logic       FRAME_ERR;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    always #10 CLK = ~CLK;

    uart_rx_fifo dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RXD       (RXD),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .OVERRUN   (OVERRUN),
        .FRAME_ERR (FRAME_ERR),
        .ERR_CLR   (ERR_CLR),
        .BUSY      (BUSY)
    );

    // Drives one frame starting at a negedge; the stop level is left on the line.
    task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_lvl);
        RXD = 1'b0;
        repeat (bc) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (bc) @(negedge CLK);
        end
        RXD = stop_lvl;
        repeat (bc) @(negedge CLK);
    endtask

    task automatic do_pop();
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
    endtask

    task automatic pulse_clr();
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({RX_VALID, OVERRUN, FRAME_ERR, BUSY} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {RX_VALID, OVERRUN, FRAME_ERR, BUSY});
        end
        checks++;
        if (RX_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h exp 00", RX_DATA);
        end
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_basic(input int bc0, input int bc1, input string tag, input bit chk_lat);
        int n;
        n = 0;
        fork
            send_byte(8'h55, bc0, 1'b1);
            begin
                while (RX_VALID !== 1'b1 && n < LAT + 100) begin
                    @(posedge CLK);
                    #1;
                    n++;
                end
            end
        join
        if (chk_lat) begin
            checks++;
            if (n < LAT - 2 || n > LAT + 2) begin
                errors++;
                $display("FAIL %s_latency got %0d exp %0d+/-2", tag, n, LAT);
            end
        end
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h55) begin
            errors++;
            $display("FAIL %s_first got v=%b d=%h exp v=1 d=55", tag, RX_VALID, RX_DATA);
        end
        send_byte(8'hA3, bc1, 1'b1);
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h55) begin
            errors++;
            $display("FAIL %s_hold got v=%b d=%h exp v=1 d=55", tag, RX_VALID, RX_DATA);
        end
        do_pop();
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'hA3) begin
            errors++;
            $display("FAIL %s_second got v=%b d=%h exp v=1 d=a3", tag, RX_VALID, RX_DATA);
        end
        do_pop();
        checks++;
        if (RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty got v=%b exp 0", tag, RX_VALID);
        end
        checks++;
        if ({OVERRUN, FRAME_ERR} !== 2'b00) begin
            errors++;
            $display("FAIL %s_flags got %b exp 00", tag, {OVERRUN, FRAME_ERR});
        end
    endtask

    task automatic test_overrun();
        logic [7:0] e;
        for (int i = 1; i <= 4; i++) begin
            e = 8'(i);
            send_byte(e, CPB, 1'b1);
        end
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ovr_at_full got %b exp 0", OVERRUN);
        end
        send_byte(8'h05, CPB, 1'b1);
        checks++;
        if (OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set got %b exp 1", OVERRUN);
        end
        for (int i = 1; i <= 4; i++) begin
            e = 8'(i);
            checks++;
            if (RX_VALID !== 1'b1 || RX_DATA !== e) begin
                errors++;
                $display("FAIL ovr_pop%0d got v=%b d=%h exp v=1 d=%h", i, RX_VALID, RX_DATA, e);
            end
            do_pop();
        end
        checks++;
        if (RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL ovr_empty got v=%b exp 0", RX_VALID);
        end
        pulse_clr();
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr got %b exp 0", OVERRUN);
        end
    endtask

    task automatic test_frame_err();
        send_byte(8'h7E, CPB, 1'b0);
        checks++;
        if ({FRAME_ERR, RX_VALID, BUSY} !== 3'b101) begin
            errors++;
            $display("FAIL ferr_set got fe/v/busy=%b exp 101", {FRAME_ERR, RX_VALID, BUSY});
        end
        repeat (1000) @(negedge CLK);
        checks++;
        if ({FRAME_ERR, BUSY} !== 2'b11) begin
            errors++;
            $display("FAIL ferr_break got fe/busy=%b exp 11", {FRAME_ERR, BUSY});
        end
        RXD = 1'b1;
        repeat (10) @(negedge CLK);
        checks++;
        if ({BUSY, RX_VALID} !== 2'b00) begin
            errors++;
            $display("FAIL ferr_release got busy/v=%b exp 00", {BUSY, RX_VALID});
        end
        send_byte(8'h42, CPB, 1'b1);
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h42) begin
            errors++;
            $display("FAIL ferr_next got v=%b d=%h exp v=1 d=42", RX_VALID, RX_DATA);
        end
        do_pop();
        pulse_clr();
        checks++;
        if ({FRAME_ERR, RX_VALID} !== 2'b00) begin
            errors++;
            $display("FAIL ferr_clr got fe/v=%b exp 00", {FRAME_ERR, RX_VALID});
        end
    endtask

    task automatic test_glitch();
        RXD = 1'b0;
        repeat (50) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy got %b exp 1", BUSY);
        end
        repeat (50) @(negedge CLK);
        RXD = 1'b1;
        repeat (400) @(negedge CLK);
        checks++;
        if ({BUSY, RX_VALID, OVERRUN, FRAME_ERR} !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_idle got %b exp 0000", {BUSY, RX_VALID, OVERRUN, FRAME_ERR});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            e = 8'h11 + 8'(i);
            send_byte(e, CPB, 1'b1);
        end
        // Pop lands exactly on the stop-bit sample edge of the fifth frame.
        fork
            send_byte(8'h15, CPB, 1'b1);
            begin
                repeat (LAT - 1) @(negedge CLK);
                RX_READY = 1'b1;
                @(negedge CLK);
                RX_READY = 1'b0;
            end
        join
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun got %b exp 0", OVERRUN);
        end
        for (int i = 0; i < 4; i++) begin
            e = 8'h12 + 8'(i);
            checks++;
            if (RX_VALID !== 1'b1 || RX_DATA !== e) begin
                errors++;
                $display("FAIL b2b_pop%0d got v=%b d=%h exp v=1 d=%h", i, RX_VALID, RX_DATA, e);
            end
            do_pop();
        end
        checks++;
        if (RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got v=%b exp 0", RX_VALID);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hA5;
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RXD = b[4];
        repeat (CPB / 2) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL rmid_busy got %b exp 1", BUSY);
        end
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({RX_VALID, OVERRUN, FRAME_ERR, BUSY} !== 4'b0000 || RX_DATA !== 8'h00) begin
            errors++;
            $display("FAIL rmid_in_reset got flags=%b d=%h exp 0000 d=00",
                     {RX_VALID, OVERRUN, FRAME_ERR, BUSY}, RX_DATA);
        end
        RXD = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2 * CPB) @(negedge CLK);
        checks++;
        if ({BUSY, RX_VALID} !== 2'b00) begin
            errors++;
            $display("FAIL rmid_after got busy/v=%b exp 00", {BUSY, RX_VALID});
        end
        send_byte(8'hC3, CPB, 1'b1);
        checks++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'hC3) begin
            errors++;
            $display("FAIL rmid_byte got v=%b d=%h exp v=1 d=c3", RX_VALID, RX_DATA);
        end
        do_pop();
        checks++;
        if (RX_VALID !== 1'b0) begin
            errors++;
            $display("FAIL rmid_empty got v=%b exp 0", RX_VALID);
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_basic(CPB, CPB, "basic", 1'b1);
        test_overrun();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        // +2% slow then -2% fast sender bit periods
        test_basic(443, 425, "baud", 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
